mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch (IF) and data (DM) requesters, with wait-cycle timeout.
// Define MEM_ARBITER_RR_EN for round-robin on collisions; otherwise DM has fixed priority.
module mem_arbiter #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_done,
  output logic [31:0] dm_rdata,
  output logic        dm_stall,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic       we_q;
  logic       if_elig, dm_elig, pick_dm, timeout, finish;

  // A requester whose done is pulsing this cycle is still holding req from the finished access.
  assign if_elig = if_req & ~if_done;
  assign dm_elig = dm_req & ~dm_done;

`ifdef MEM_ARBITER_RR_EN
  logic last_dm;
  assign pick_dm = dm_elig & (~if_elig | ~last_dm);
`else
  assign pick_dm = dm_elig;
`endif

  assign timeout  = (state != IDLE) & ~mem_ready & (wait_cnt == MAX_CNT);
  assign finish   = (state != IDLE) & (mem_ready | timeout);
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_dm)      state_nxt = GNT_DM;
        else if (if_elig) state_nxt = GNT_IF;
      end
      GNT_IF, GNT_DM: if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (state)
      GNT_IF: mem_req = 1'b1;
      GNT_DM: begin
        mem_req = 1'b1;
        mem_we  = we_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      wait_cnt  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      err       <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_done <= (state == GNT_IF) & finish;
      dm_done <= (state == GNT_DM) & finish;
      err     <= timeout;
      if (state == IDLE) begin
        wait_cnt <= '0;
        if (pick_dm) begin
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
          we_q      <= dm_we;
        end else if (if_elig) begin
          mem_addr <= if_addr;
          we_q     <= 1'b0;
        end
      end else if (!mem_ready) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (state == GNT_IF && mem_ready)          if_rdata <= mem_rdata;
      if (state == GNT_DM && mem_ready && !we_q) dm_rdata <= mem_rdata;
    end
  end

`ifdef MEM_ARBITER_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 last_dm <= 1'b0;
    else if (state == IDLE && (pick_dm | if_elig)) last_dm <= pick_dm;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MAX_WAIT=4); inputs driven 1ns after rising edge, outputs sampled on falling edge.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_done, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_done, dm_stall;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        err, mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_if_rd, exp_dm_rd;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    mem_rdata = 0; mem_ready = 0;
    #2 rst_n = 1'b0;
    #10;
    n_vec++;
    if ({mem_req, mem_we, if_done, dm_done, err, if_stall, dm_stall} !== 7'b0) begin
      n_err++; $display("FAIL reset_ctl: got %b want 0", {mem_req, mem_we, if_done, dm_done, err, if_stall, dm_stall});
    end
    n_vec++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      n_err++; $display("FAIL reset_addr: got %h %h want 0", mem_addr, mem_wdata);
    end
    n_vec++;
    if ({if_rdata, dm_rdata} !== 64'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h %h want 0", if_rdata, dm_rdata);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    exp_if_rd = 0; exp_dm_rd = 0;
  endtask

  task automatic test_if_read();
    tick(); if_req = 1; if_addr = 32'h40; mem_ready = 1; mem_rdata = 32'h8C010010;
    @(negedge clk); n_vec++;
    if ({mem_req, if_stall, if_done} !== 3'b010) begin
      n_err++; $display("FAIL ifrd_c0: got req/stall/done %b want 010", {mem_req, if_stall, if_done});
    end
    tick(); @(negedge clk); n_vec++;
    if ({mem_req, mem_we, if_stall, mem_addr} !== {3'b101, 32'h40}) begin
      n_err++; $display("FAIL ifrd_c1: got %b addr %h want 101 addr 40", {mem_req, mem_we, if_stall}, mem_addr);
    end
    tick(); @(negedge clk); n_vec++;
    exp_if_rd = 32'h8C010010;
    if ({if_done, if_stall, mem_req, if_rdata} !== {3'b100, exp_if_rd}) begin
      n_err++; $display("FAIL ifrd_c2: got %b data %h want 100 data %h", {if_done, if_stall, mem_req}, if_rdata, exp_if_rd);
    end
    tick(); if_req = 0; @(negedge clk); n_vec++;
    if ({if_done, mem_req} !== 2'b00) begin
      n_err++; $display("FAIL ifrd_c3_noregrant: got %b want 00", {if_done, mem_req});
    end
  endtask

  task automatic test_dm_read();
    tick(); dm_req = 1; dm_we = 0; dm_addr = 32'h20; mem_ready = 1; mem_rdata = 32'h12345678;
    tick(); @(negedge clk); n_vec++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h20}) begin
      n_err++; $display("FAIL dmrd_c1: got %b addr %h want 10 addr 20", {mem_req, mem_we}, mem_addr);
    end
    tick(); @(negedge clk); n_vec++;
    exp_dm_rd = 32'h12345678;
    if ({dm_done, if_done, err, dm_rdata, if_rdata} !== {3'b100, exp_dm_rd, exp_if_rd}) begin
      n_err++; $display("FAIL dmrd_c2: got %b %h %h want 100 %h %h", {dm_done, if_done, err}, dm_rdata, if_rdata, exp_dm_rd, exp_if_rd);
    end
    tick(); dm_req = 0;
  endtask

  task automatic test_dm_write();
    tick(); dm_req = 1; dm_we = 1; dm_addr = 32'h10; dm_wdata = 32'hCAFE0001; mem_ready = 0; mem_rdata = 32'hDEADBEEF;
    for (int k = 1; k <= 4; k++) begin
      tick(); mem_ready = (k == 4); @(negedge clk); n_vec++;
      if ({mem_req, mem_we, dm_done, mem_addr, mem_wdata} !== {3'b110, 32'h10, 32'hCAFE0001}) begin
        n_err++; $display("FAIL dmwr_c%0d: got %b %h %h want 110 10 cafe0001", k, {mem_req, mem_we, dm_done}, mem_addr, mem_wdata);
      end
    end
    tick(); @(negedge clk); n_vec++;
    if ({dm_done, err, mem_req, mem_we, dm_rdata} !== {4'b1000, exp_dm_rd}) begin
      n_err++; $display("FAIL dmwr_c5: got %b rdata %h want 1000 rdata %h", {dm_done, err, mem_req, mem_we}, dm_rdata, exp_dm_rd);
    end
    tick(); dm_req = 0; dm_we = 0; @(negedge clk); n_vec++;
    if (dm_done !== 1'b0) begin
      n_err++; $display("FAIL dmwr_c6_pulse: got %b want 0", dm_done);
    end
  endtask

  task automatic test_collision();
    tick(); if_req = 1; if_addr = 32'h200; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    mem_ready = 1; mem_rdata = 32'hAAAA0001;
    tick(); @(negedge clk); n_vec++;
    if ({mem_req, if_stall, mem_addr} !== {2'b11, 32'h100}) begin
      n_err++; $display("FAIL coll_c1: got %b addr %h want 11 addr 100", {mem_req, if_stall}, mem_addr);
    end
    tick(); dm_req = 0; mem_rdata = 32'hBBBB0002; @(negedge clk); n_vec++;
    exp_dm_rd = 32'hAAAA0001;
    if ({dm_done, if_done, dm_rdata} !== {2'b10, exp_dm_rd}) begin
      n_err++; $display("FAIL coll_c2: got %b %h want 10 %h", {dm_done, if_done}, dm_rdata, exp_dm_rd);
    end
    tick(); @(negedge clk); n_vec++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h200}) begin
      n_err++; $display("FAIL coll_c3: got %b addr %h want 10 addr 200", {mem_req, mem_we}, mem_addr);
    end
    tick(); if_req = 0; @(negedge clk); n_vec++;
    exp_if_rd = 32'hBBBB0002;
    if ({if_done, dm_done, if_rdata} !== {2'b10, exp_if_rd}) begin
      n_err++; $display("FAIL coll_c4: got %b %h want 10 %h", {if_done, dm_done}, if_rdata, exp_if_rd);
    end
  endtask

  // DM granted alone first, so a following collision goes to IF only with round-robin.
  task automatic test_rr_collision();
    tick(); dm_req = 1; dm_addr = 32'h300; mem_ready = 1; mem_rdata = 32'h5A5A5A5A;
    tick(); tick();
    tick(); dm_addr = 32'h304; if_req = 1; if_addr = 32'h400;
    tick(); @(negedge clk); n_vec++;
    if (mem_addr !== (RR ? 32'h400 : 32'h304)) begin
      n_err++; $display("FAIL rr_first: got addr %h want %h", mem_addr, RR ? 32'h400 : 32'h304);
    end
    tick(); if (RR) if_req = 0; else dm_req = 0;
    @(negedge clk); n_vec++;
    if ({if_done, dm_done} !== (RR ? 2'b10 : 2'b01)) begin
      n_err++; $display("FAIL rr_done1: got %b want %b", {if_done, dm_done}, RR ? 2'b10 : 2'b01);
    end
    tick(); @(negedge clk); n_vec++;
    if (mem_addr !== (RR ? 32'h304 : 32'h400)) begin
      n_err++; $display("FAIL rr_second: got addr %h want %h", mem_addr, RR ? 32'h304 : 32'h400);
    end
    tick(); if_req = 0; dm_req = 0; @(negedge clk); n_vec++;
    if ({if_done, dm_done} !== (RR ? 2'b01 : 2'b10)) begin
      n_err++; $display("FAIL rr_done2: got %b want %b", {if_done, dm_done}, RR ? 2'b01 : 2'b10);
    end
    exp_if_rd = 32'h5A5A5A5A; exp_dm_rd = 32'h5A5A5A5A;
  endtask

  task automatic test_timeout();
    tick(); dm_req = 1; dm_we = 0; dm_addr = 32'h44; mem_ready = 0; mem_rdata = 32'hFFFF0000;
    for (int k = 1; k <= 5; k++) begin
      tick(); @(negedge clk); n_vec++;
      if ({mem_req, dm_done, err} !== 3'b100) begin
        n_err++; $display("FAIL tmo_c%0d: got req/done/err %b want 100", k, {mem_req, dm_done, err});
      end
    end
    tick(); dm_req = 0; @(negedge clk); n_vec++;
    if ({dm_done, err, mem_req, dm_rdata} !== {3'b110, exp_dm_rd}) begin
      n_err++; $display("FAIL tmo_c6: got %b rdata %h want 110 rdata %h", {dm_done, err, mem_req}, dm_rdata, exp_dm_rd);
    end
    tick(); @(negedge clk); n_vec++;
    if ({dm_done, err, mem_req} !== 3'b000) begin
      n_err++; $display("FAIL tmo_c7: got %b want 000", {dm_done, err, mem_req});
    end
  endtask

  task automatic test_ready_at_max();
    tick(); dm_req = 1; dm_we = 0; dm_addr = 32'h48; mem_ready = 0; mem_rdata = 32'h0BADF00D;
    for (int k = 1; k <= 4; k++) tick();
    tick(); mem_ready = 1; @(negedge clk); n_vec++;
    if ({mem_req, dm_done} !== 2'b10) begin
      n_err++; $display("FAIL rdymax_c5: got %b want 10", {mem_req, dm_done});
    end
    tick(); dm_req = 0; mem_ready = 0; @(negedge clk); n_vec++;
    exp_dm_rd = 32'h0BADF00D;
    if ({dm_done, err, dm_rdata} !== {2'b10, exp_dm_rd}) begin
      n_err++; $display("FAIL rdymax_c6: got %b %h want 10 %h", {dm_done, err}, dm_rdata, exp_dm_rd);
    end
  endtask

  task automatic test_drop_mid();
    tick(); if_req = 1; if_addr = 32'h84; mem_ready = 0; mem_rdata = 32'h600D0001;
    tick(); @(negedge clk); n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h84}) begin
      n_err++; $display("FAIL drop_c1: got %b addr %h want 1 addr 84", mem_req, mem_addr);
    end
    tick(); if_req = 0; mem_ready = 1; @(negedge clk); n_vec++;
    if ({mem_req, if_stall, if_done} !== 3'b100) begin
      n_err++; $display("FAIL drop_c2: got %b want 100", {mem_req, if_stall, if_done});
    end
    tick(); mem_ready = 0; @(negedge clk); n_vec++;
    exp_if_rd = 32'h600D0001;
    if ({if_done, mem_req, if_rdata} !== {2'b10, exp_if_rd}) begin
      n_err++; $display("FAIL drop_c3: got %b %h want 10 %h", {if_done, mem_req}, if_rdata, exp_if_rd);
    end
  endtask

  task automatic test_reset_mid();
    tick(); if_req = 1; if_addr = 32'h80; mem_ready = 0; mem_rdata = 32'h77770000;
    tick();
    tick(); rst_n = 0; #1; n_vec++;
    if ({mem_req, if_done, if_rdata} !== {2'b00, 32'h0}) begin
      n_err++; $display("FAIL rstmid_async: got %b %h want 00 0", {mem_req, if_done}, if_rdata);
    end
    tick(); rst_n = 1; @(negedge clk); n_vec++;
    if ({mem_req, if_done} !== 2'b00) begin
      n_err++; $display("FAIL rstmid_held: got %b want 00", {mem_req, if_done});
    end
    tick(); mem_ready = 1; @(negedge clk); n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin
      n_err++; $display("FAIL rstmid_regrant: got %b addr %h want 1 addr 80", mem_req, mem_addr);
    end
    tick(); if_req = 0; mem_ready = 0; @(negedge clk); n_vec++;
    if ({if_done, if_rdata} !== {1'b1, 32'h77770000}) begin
      n_err++; $display("FAIL rstmid_done: got %b %h want 1 77770000", if_done, if_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_dm_read();
    test_dm_write();
    test_collision();
    test_rr_collision();
    test_timeout();
    test_ready_at_max();
    test_drop_mid();
    test_reset_mid();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
